// File: rtl/color_pkg.sv
// Shared colour-code constants and decoder state type for the digit-colour encoder/decoder pair.
package color_pkg;

  localparam logic [11:0] COLOR_DIGIT_0 = 12'hFFF;
  localparam logic [11:0] COLOR_DIGIT_1 = 12'hF00;
  localparam logic [11:0] COLOR_DIGIT_2 = 12'h0F0;
  localparam logic [11:0] COLOR_DIGIT_3 = 12'h00F;
  localparam logic [11:0] COLOR_DIGIT_4 = 12'hE1F;
  localparam logic [11:0] COLOR_DIGIT_5 = 12'hFC0;
  localparam logic [11:0] COLOR_DIGIT_6 = 12'h940;
  localparam logic [11:0] COLOR_DIGIT_7 = 12'h3DF;
  localparam logic [11:0] COLOR_DIGIT_8 = 12'h250;
  localparam logic [11:0] COLOR_DIGIT_9 = 12'h92E;
  localparam logic [11:0] COLOR_BLACK   = 12'h000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_TENS = 2'd1,
    RESULT   = 2'd2
  } state_e;

endpackage

// File: rtl/color_to_digit.sv
// Combinational lookup from an exact 12-bit RGB444 colour code to a decimal digit.
module color_to_digit
  import color_pkg::*;
(
  input  logic [11:0] color,
  output logic        known,
  output logic [3:0]  digit
);

  always_comb begin
    known = 1'b1;
    digit = 4'd0;
    case (color)
      COLOR_DIGIT_0: digit = 4'd0;
      COLOR_DIGIT_1: digit = 4'd1;
      COLOR_DIGIT_2: digit = 4'd2;
      COLOR_DIGIT_3: digit = 4'd3;
      COLOR_DIGIT_4: digit = 4'd4;
      COLOR_DIGIT_5: digit = 4'd5;
      COLOR_DIGIT_6: digit = 4'd6;
      COLOR_DIGIT_7: digit = 4'd7;
      COLOR_DIGIT_8: digit = 4'd8;
      COLOR_DIGIT_9: digit = 4'd9;
      default:       known = 1'b0;
    endcase
  end

endmodule

// File: rtl/color_decoder.sv
// Reassembles a 6-bit number from a tens-colour beat followed by a ones-colour beat,
// flagging unknown colours, out-of-range values, protocol desync and inter-beat timeout.
module color_decoder
  import color_pkg::*;
#(
  parameter int TIMEOUT = 200,
  parameter int TIMER_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_color,
  input  logic        in_first,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  num,
  output logic [1:0]  err,
  output logic        desync,
  output logic        timeout
);

  localparam logic [TIMER_W-1:0] TIMEOUT_CNT = TIMER_W'(TIMEOUT);

  state_e              state_q, state_d;
  logic [3:0]          tens_q, tens_d;
  logic                tens_unk_q, tens_unk_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [5:0]          num_q, num_d;
  logic [1:0]          err_q, err_d;
  logic                desync_q, desync_d;
  logic                timeout_q, timeout_d;

  logic       beat_known;
  logic [3:0] beat_digit;
  logic       beat;
  logic [6:0] value;

  // Only one beat can arrive per cycle, so a single lookup serves both digits.
  color_to_digit u_lookup (
    .color (in_color),
    .known (beat_known),
    .digit (beat_digit)
  );

  assign in_ready  = !rst && (state_q != RESULT);
  assign beat      = in_valid && in_ready;
  assign value     = ({3'b000, tens_q} * 7'd10) + {3'b000, beat_digit};
  assign out_valid = (state_q == RESULT);
  assign num       = num_q;
  assign err       = err_q;
  assign desync    = desync_q;
  assign timeout   = timeout_q;

  always_comb begin
    state_d    = state_q;
    tens_d     = tens_q;
    tens_unk_d = tens_unk_q;
    timer_d    = timer_q;
    num_d      = num_q;
    err_d      = err_q;
    desync_d   = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (beat) begin
          if (in_first) begin
            tens_d     = beat_digit;
            tens_unk_d = !beat_known;
            timer_d    = '0;
            state_d    = GOT_TENS;
          end else begin
            desync_d = 1'b1;
          end
        end
      end
      GOT_TENS: begin
        if (beat) begin
          timer_d = '0;
          if (in_first) begin
            tens_d     = beat_digit;
            tens_unk_d = !beat_known;
            desync_d   = 1'b1;
          end else begin
            err_d[0] = tens_unk_q || !beat_known;
            err_d[1] = !tens_unk_q && beat_known && (value > 7'd63);
            num_d    = (err_d == 2'b00) ? value[5:0] : 6'd0;
            state_d  = RESULT;
          end
        end else if (TIMEOUT != 0) begin
          timer_d = timer_q + 1'b1;
          if (timer_d == TIMEOUT_CNT) begin
            timer_d    = '0;
            tens_d     = '0;
            tens_unk_d = 1'b0;
            timeout_d  = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      RESULT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tens_q     <= '0;
      tens_unk_q <= 1'b0;
      timer_q    <= '0;
      num_q      <= '0;
      err_q      <= '0;
      desync_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tens_q     <= tens_d;
      tens_unk_q <= tens_unk_d;
      timer_q    <= timer_d;
      num_q      <= num_d;
      err_q      <= err_d;
      desync_q   <= desync_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_color_decoder.sv
// Directed self-checking bench for color_decoder with a short timeout setting.
module tb_color_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_color;
  logic        in_first;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  num;
  logic [1:0]  err;
  logic        desync;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  color_decoder #(.TIMEOUT(16), .TIMER_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_color  (in_color),
    .in_first  (in_first),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .num       (num),
    .err       (err),
    .desync    (desync),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [11:0] color, input logic first);
    chk("in_ready_before_beat", in_ready, 1);
    in_valid = 1'b1;
    in_color = color;
    in_first = first;
    step();
    in_valid = 1'b0;
    $display("beat color=%03h first=%0d -> out_valid=%0d num=%0d err=%b desync=%0d",
             color, first, out_valid, num, err, desync);
  endtask

  // Full number: tens, ones, then a handshake with out_ready held high.
  task automatic pair(input string tag, input logic [11:0] tens, input logic [11:0] ones,
                      input logic [5:0] exp_num, input logic [1:0] exp_err);
    out_ready = 1'b1;
    send_beat(tens, 1'b1);
    chk({tag, "_no_early_valid"}, out_valid, 0);
    chk({tag, "_no_desync"}, desync, 0);
    send_beat(ones, 1'b0);
    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_num"}, num, exp_num);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_in_ready_low"}, in_ready, 0);
    step();
    chk({tag, "_released"}, out_valid, 0);
    $display("txn %s tens=%03h ones=%03h num=%0d err=%b", tag, tens, ones, exp_num, exp_err);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_color = 12'h000;
    in_first = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_num", num, 0);
    chk("rst_err", err, 0);
    chk("rst_desync", desync, 0);
    chk("rst_timeout", timeout, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    pair("t1_24", 12'h0F0, 12'hE1F, 6'd24, 2'b00);
    pair("t2_63", 12'h940, 12'h00F, 6'd63, 2'b00);
    pair("t2_65", 12'h940, 12'hFC0, 6'd0, 2'b10);
    pair("t3_unk_tens", 12'h123, 12'hF00, 6'd0, 2'b01);
    pair("t3_black", 12'hFFF, 12'h000, 6'd0, 2'b01);

    // Ones beat in IDLE, then a repeated tens beat.
    send_beat(12'hF00, 1'b0);
    chk("t4_desync_idle", desync, 1);
    chk("t4_no_result", out_valid, 0);
    step();
    chk("t4_desync_clear", desync, 0);
    send_beat(12'hFC0, 1'b1);
    chk("t4_first_tens_no_desync", desync, 0);
    send_beat(12'hF00, 1'b1);
    chk("t4_desync_retens", desync, 1);
    send_beat(12'h3DF, 1'b0);
    chk("t4_desync_clear2", desync, 0);
    chk("t4_valid", out_valid, 1);
    chk("t4_num17", num, 17);
    chk("t4_err", err, 0);
    step();
    chk("t4_released", out_valid, 0);
    $display("txn t4 desync then num=17");

    // Timeout after 16 idle cycles in GOT_TENS.
    send_beat(12'h250, 1'b1);
    for (int i = 1; i <= 15; i++) begin
      step();
      chk("t5_no_early_timeout", timeout, 0);
    end
    step();
    chk("t5_timeout_pulse", timeout, 1);
    chk("t5_in_ready_idle", in_ready, 1);
    step();
    chk("t5_timeout_clear", timeout, 0);
    send_beat(12'h00F, 1'b0);
    chk("t5_desync_after_timeout", desync, 1);
    chk("t5_no_result", out_valid, 0);
    step();
    $display("txn t5 timeout then stray ones beat");

    // Result held with out_ready low; a beat offered meanwhile must be refused.
    out_ready = 1'b0;
    send_beat(12'h0F0, 1'b1);
    send_beat(12'h92E, 1'b0);
    in_valid = 1'b1;
    in_color = 12'hF00;
    in_first = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t6_hold_valid", out_valid, 1);
      chk("t6_hold_num", num, 29);
      chk("t6_hold_err", err, 0);
      chk("t6_hold_in_ready", in_ready, 0);
      chk("t6_hold_no_desync", desync, 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("t6_released", out_valid, 0);
    chk("t6_idle_ready", in_ready, 1);
    $display("txn t6 held result num=29");

    // Reset in GOT_TENS drops the pending tens digit.
    send_beat(12'h250, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("t6_rst_no_valid", out_valid, 0);
    send_beat(12'hFFF, 1'b0);
    chk("t6_rst_desync", desync, 1);
    chk("t6_rst_no_result", out_valid, 0);
    step();
    $display("txn t6 reset in GOT_TENS");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/color_decoder.md
Name: color_decoder

Overview:
- Inverse of the digit-colour encoder: recovers a 6-bit number from a two-beat stream of 12-bit RGB colour codes.
  - Beat 1 is the tens-digit colour; beat 2 is the ones-digit colour.
- Sits on the input side of the display/test path. Decodes colour pairs coming back from a capture/compare channel into the number they represent.
- Reports unknown colours, out-of-range values, protocol desync and inter-beat timeout.

Parameters:
TIMEOUT, 200, max cycles allowed in GOT_TENS without an accepted beat; 0 disables the timer
TIMER_W, 8, width of the timeout counter; must satisfy TIMEOUT < 2**TIMER_W

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
in_valid  in  1  colour beat valid
in_ready  out  1  decoder can accept a beat
in_color  in  12  RGB444 colour code
in_first  in  1  1 = tens beat, 0 = ones beat
out_valid  out  1  decoded result valid
out_ready  in  1  consumer accepts result
num  out  6  decoded number (0..63)
err  out  2  bit0 = unknown colour in either beat; bit1 = value > 63
desync  out  1  one-cycle pulse on a protocol violation
timeout  out  1  one-cycle pulse on inter-beat timeout

Behaviour:
- Single clock (clk); reset is synchronous and active-high (rst).
- Reset state:
  - state IDLE; out_valid 0; num 0; err 00; desync 0; timeout 0; timer 0.
  - in_ready is 0 while rst is high.
- Colour lookup (exact match, all 12 bits):
  - FFF->0, F00->1, 0F0->2, 00F->3, E1F->4, FC0->5, 940->6, 3DF->7, 250->8, 92E->9.
  - Any other value, including 000, is unknown.
- A beat is accepted when in_valid & in_ready.
- in_ready = 1 in IDLE and GOT_TENS; 0 in RESULT.
- State IDLE:
  - Accepted beat with in_first=1: latch tens digit and its unknown flag, clear timer, go to GOT_TENS.
  - Accepted beat with in_first=0: discard it, pulse desync, stay in IDLE.
- State GOT_TENS:
  - Accepted beat with in_first=1: replace the tens digit, restart the timer, pulse desync.
  - Accepted beat with in_first=0: compute value = tens*10 + ones as a 7-bit result (max 99), register the outputs, go to RESULT.
  - No accepted beat: timer increments each cycle. When it reaches TIMEOUT (and TIMEOUT != 0), go to IDLE, pulse timeout, and drop the latched tens.
- State RESULT:
  - out_valid = 1.
  - num, err and out_valid are registered and held stable until out_valid & out_ready; then go to IDLE.
- Output values:
  - err[0] = tens unknown OR ones unknown.
  - err[1] = both digits known AND value > 63.
  - If err != 00, num = 0; otherwise num = value[5:0].
- Timing:
  - Latency: out_valid rises the cycle after the ones beat is accepted.
  - Minimum period: 3 cycles per number.
- Boundary cases:
  - No overlap between a result handshake and an input beat (in_ready = 0 in RESULT).
  - out_ready is ignored outside RESULT.
  - rst in any state returns to IDLE the next cycle; any partial or pending result is lost.
  - desync and timeout never assert in the same cycle, because a beat restarts the timer.

Decomposition:
- Package color_pkg holds:
  - ten COLOR_DIGIT_n localparams (12-bit);
  - COLOR_BLACK = 12'h000;
  - the state enumeration IDLE / GOT_TENS / RESULT.
- The existing encoder is to import the same colour constants from color_pkg.
- One sub-module: color_to_digit.
  - Combinational; in: 12-bit colour; out: known flag plus 4-bit digit.
  - Instantiated once on in_color, since only one beat arrives per cycle.

Test Plan:
1. Tens 0F0, ones E1F, out_ready=1 -> num=24, err=00; out_valid rises exactly one cycle after the ones beat.
2. Tens 940, ones 00F -> num=63, err=00. Then tens 940, ones FC0 -> num=0, err=10.
3. Tens 123, ones F00 -> num=0, err=01. Then tens FFF, ones 000 -> num=0, err=01.
4. Ones beat in IDLE -> desync pulse, no result. Then tens FC0, tens F00, ones 3DF -> second desync pulse, num=17.
5. TIMEOUT=16; tens beat, then idle 16 cycles -> timeout pulse, state IDLE. A following ones beat gives desync and no result.
6. Hold out_ready=0 for 10 cycles in RESULT -> num/err/out_valid stable, in_ready=0. Separately, assert rst in GOT_TENS -> the subsequent ones beat gives desync and no result.
